compressor_arbiter: RTL

- Shares one 256-bit Compressor input port between NUM_REQ requesters.
- Round-robin, packet-locked arbitration: a grant holds until the owner's last beat.
- Drives the compressor's push/data/write-enable inputs and tracks compressor input-FIFO credits so that no push is ever dropped.
- Provides a flush sequence that waits until the compressor has consumed every accepted word.

---
 rtl/compressor_pkg.sv | 39 +++
 rtl/compressor_credit_ctr.sv | 43 ++++
 rtl/compressor_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/compressor_pkg.sv
// Shared definitions for the compressor input-port arbiter.
//   CMP_DATA_W  : compressor data_in width
//   CMP_TAG_W   : compressor tag width (kept here for sibling blocks)
//   arb_state_e : arbiter FSM states
//   rr_pick     : round-robin search helper (up to RR_MAX requesters)
package compressor_pkg;

  localparam int CMP_DATA_W = 256;
  localparam int CMP_TAG_W  = 16;
  localparam int RR_MAX     = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_FLUSH = 2'd2
  } arb_state_e;

  // Returns the first set bit of valid at or above ptr, wrapping at n.
  // Only the first n positions are searched, so non-power-of-2 counts work.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(k) < n) && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/compressor_credit_ctr.sv
// Credit counter for the compressor input FIFO.
//   clk, reset  : clock, synchronous active-high reset
//   take        : one word pushed this cycle (consumes a credit)
//   give        : compressor popped one word (returns a credit)
//   credits     : credits currently available, resets to FIFO_DEPTH
//   has_credit  : credits != 0
//   credit_err  : sticky, a give arrived while credits were already full
module compressor_credit_ctr #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] credits,
  output logic          has_credit,
  output logic          credit_err
);

  logic full;
  logic give_ok;

  assign full       = (credits == CW'(FIFO_DEPTH));
  assign has_credit = (credits != '0);
  // A return while full cannot correspond to a real word; drop it.
  assign give_ok    = give && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      credits    <= CW'(FIFO_DEPTH);
      credit_err <= 1'b0;
    end else begin
      if (give && full) credit_err <= 1'b1;
      case ({take, give_ok})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: rtl/compressor_arbiter.sv
// Round-robin, packet-locked arbiter sharing one compressor input port.
// Optional per-requester accepted-beat counters: COMPRESSOR_ARB_STATS_EN.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/last/data   : per-requester beat stream (data flattened)
//   req_ready             : per-requester accept (owner only, in BURST)
//   cmp_pop               : compressor consumed a word (credit return)
//   cmp_wrt_en/push/data/src : registered compressor input side
//   flush_req/flush_done  : drain request / completion pulse
//   credit_err            : sticky credit overflow indicator
//   stat_sel/stat_cnt     : (stats build only) counter read port, 1-cycle latency
//   dbg_*                 : FSM state, credits, round-robin pointer, owner, flush pending
// Handshake: a beat transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on req_valid, and a
// requester keeps valid/data/last stable until the transfer happens.
module compressor_arbiter
  import compressor_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = CMP_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int OW         = $clog2(NUM_REQ),
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  cmp_pop,
  output logic                  cmp_wrt_en,
  output logic                  cmp_push,
  output logic [DATA_W-1:0]     cmp_data,
  output logic [OW-1:0]         cmp_src,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  credit_err,
`ifdef COMPRESSOR_ARB_STATS_EN
  input  logic [OW-1:0]         stat_sel,
  output logic [31:0]           stat_cnt,
`endif
  output logic [1:0]            dbg_state,
  output logic [CW-1:0]         dbg_credits,
  output logic [OW-1:0]         dbg_rr_ptr,
  output logic [OW-1:0]         dbg_owner,
  output logic                  dbg_flush_pend
);

  arb_state_e        state;
  logic [OW-1:0]     rr_ptr;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     owner_inc;
  logic [OW-1:0]     pick;
  logic              flush_pend;
  logic [CW-1:0]     credits;
  logic              has_credit;
  logic              accept;
  logic              flush_fire;
  logic [DATA_W-1:0] beats [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_beats
    assign beats[g] = req_data[g*DATA_W +: DATA_W];
  end

  compressor_credit_ctr #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CW        (CW)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .take      (accept),
    .give      (cmp_pop),
    .credits   (credits),
    .has_credit(has_credit),
    .credit_err(credit_err)
  );

  always_comb begin
    req_ready = '0;
    if (state == ARB_BURST && has_credit) req_ready[owner] = 1'b1;
  end

  assign accept     = (state == ARB_BURST) && has_credit && req_valid[owner];
  assign owner_inc  = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
  assign pick       = OW'(rr_pick(RR_MAX'(req_valid), 3'(rr_ptr), 4'(NUM_REQ)));
  // Drained: every credit is back and no word is in flight on the push path.
  assign flush_fire = (state == ARB_FLUSH) && (credits == CW'(FIFO_DEPTH)) && !cmp_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      flush_pend <= 1'b0;
      cmp_push   <= 1'b0;
      cmp_data   <= '0;
      cmp_src    <= '0;
      cmp_wrt_en <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      cmp_wrt_en <= 1'b1;
      cmp_push   <= accept;
      flush_done <= flush_fire;
      if (accept) begin
        cmp_data <= beats[owner];
        cmp_src  <= owner;
      end
      // Requests arriving during FLUSH fold into the flush in progress.
      flush_pend <= flush_fire ? 1'b0 : (flush_pend | flush_req);
      case (state)
        ARB_IDLE: begin
          if (flush_pend) begin
            state <= ARB_FLUSH;
          end else if ((|req_valid) && has_credit) begin
            owner <= pick;
            state <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (accept && req_last[owner]) begin
            rr_ptr <= owner_inc;
            state  <= ARB_IDLE;
          end
        end
        ARB_FLUSH: begin
          if (flush_fire) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef COMPRESSOR_ARB_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (accept) stat_q[owner] <= stat_q[owner] + 32'd1;
      stat_cnt <= stat_q[stat_sel];
    end
  end
`endif

  assign dbg_state      = state;
  assign dbg_credits    = credits;
  assign dbg_rr_ptr     = rr_ptr;
  assign dbg_owner      = owner;
  assign dbg_flush_pend = flush_pend;

endmodule
